// File: rtl/frame_pkg.sv
// Shared frame layout constants, confirmation codes and relay FSM state type
// for the plain/secret frame relay.
package frame_pkg;

  localparam int unsigned PREAMBLE_SIZE = 7;
  localparam int unsigned DATA_SIZE     = 64;
  localparam int unsigned CRC_SIZE      = 4;
  localparam int unsigned NONCE_SIZE    = 12;
  localparam int unsigned FRAME_BYTES   = PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE + NONCE_SIZE;
  localparam int unsigned FRAME_BITS    = FRAME_BYTES * 8;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] FTYPE_PLAIN   = 8'h01;
  localparam logic [7:0] FTYPE_SECRET  = 8'h02;
  localparam logic [7:0] FLAG_NONE     = 8'h00;
  localparam logic [7:0] FLAG_RETX     = 8'h80;

  localparam logic [7:0] OKAY        = 8'h05;
  localparam logic [7:0] ERROR       = 8'h04;
  localparam logic [7:0] FATAL_ERROR = 8'h08;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_CONF,
    REPORT
  } relay_state_t;

  // Even port indices face the plain side, odd ones the secret side.
  function automatic logic is_secret_port(input int unsigned idx);
    return idx[0];
  endfunction

endpackage

// File: rtl/frame_relay_core_if.sv
// Frame / confirmation bus between the relay core and its NUM_PORTS
// Interface + PC pairs. master = port side, slave = relay core.
interface frame_relay_core_if #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned FRAME_BITS = frame_pkg::FRAME_BITS
);

  logic [NUM_PORTS*FRAME_BITS-1:0] fin;
  logic [NUM_PORTS-1:0]            fin_valid;
  logic [NUM_PORTS-1:0]            fin_ready;
  logic [FRAME_BITS-1:0]           fout;
  logic [NUM_PORTS-1:0]            fout_valid;
  logic [NUM_PORTS-1:0]            fout_ready;
  logic [NUM_PORTS*8-1:0]          conf_in;
  logic [NUM_PORTS-1:0]            conf_in_valid;
  logic [7:0]                      conf_out;
  logic [NUM_PORTS-1:0]            conf_out_valid;

  modport master (
    output fin, fin_valid, fout_ready, conf_in, conf_in_valid,
    input  fin_ready, fout, fout_valid, conf_out, conf_out_valid
  );

  modport slave (
    input  fin, fin_valid, fout_ready, conf_in, conf_in_valid,
    output fin_ready, fout, fout_valid, conf_out, conf_out_valid
  );

endinterface

// File: rtl/frame_relay_core_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr (wrapping) wins.
module rr_arbiter #(
  parameter int unsigned NUM_PORTS = 2,
  localparam int unsigned IDX_W    = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_vld
);

  always_comb begin
    int unsigned j;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    j         = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      j = 32'(ptr) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!grant_vld && req[IDX_W'(j)]) begin
        grant_vld           = 1'b1;
        grant[IDX_W'(j)]    = 1'b1;
        grant_idx           = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/frame_relay_core.sv
// N-port frame relay: forwards each frame to port src^1, relays the PC's
// confirmation back, retries on ERROR. Optional macro: RELAY_TIMEOUT_EN.
module frame_relay_core #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned FRAME_BITS  = frame_pkg::FRAME_BITS,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  frame_relay_core_if.slave        bus,
  output logic                     busy,
  output logic [15:0]              fatal_cnt
);

  import frame_pkg::*;

  localparam int unsigned IDX_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;

  if (NUM_PORTS < 2 || (NUM_PORTS % 2) != 0 || MAX_RETRY > 15 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("frame_relay_core: unsupported parameter set");
  end

  relay_state_t          state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      src_q, src_d;
  logic [IDX_W-1:0]      dst;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [3:0]            retry_q, retry_d;
  logic [7:0]            code_q, code_d;
  logic [15:0]           fatal_q;
  logic [NUM_PORTS-1:0]  grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_vld;
  logic [7:0]            dst_code;
  logic                  dst_strobe;
  logic                  tmo_hit;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .req       (bus.fin_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign dst        = src_q ^ IDX_W'(1);
  assign dst_code   = bus.conf_in[{dst, 3'b000} +: 8];
  assign dst_strobe = bus.conf_in_valid[dst];

`ifdef RELAY_TIMEOUT_EN
  logic [31:0] tmo_q;

  // Held at zero outside WAIT_CONF, so every entry starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    tmo_q <= '0;
    else if (state_q != WAIT_CONF) tmo_q <= '0;
    else                           tmo_q <= tmo_q + 32'd1;
  end

  assign tmo_hit = (state_q == WAIT_CONF) && (tmo_q == 32'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d            = state_q;
    ptr_d              = ptr_q;
    src_d              = src_q;
    frame_d            = frame_q;
    retry_d            = retry_q;
    code_d             = code_q;
    bus.fin_ready      = '0;
    bus.fout_valid     = '0;
    bus.conf_out       = '0;
    bus.conf_out_valid = '0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          bus.fin_ready = grant;
          frame_d       = bus.fin[grant_idx*FRAME_BITS +: FRAME_BITS];
          src_d         = grant_idx;
          retry_d       = '0;
          ptr_d         = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + IDX_W'(1);
          state_d       = SEND;
        end
      end
      SEND: begin
        bus.fout_valid = NUM_PORTS'(1) << dst;
        if (bus.fout_ready[dst]) state_d = WAIT_CONF;
      end
      WAIT_CONF: begin
        // A timeout only counts when no strobe arrives in the same cycle.
        if (dst_strobe && dst_code == OKAY) begin
          code_d  = OKAY;
          state_d = REPORT;
        end else if ((dst_strobe && dst_code == ERROR) || (!dst_strobe && tmo_hit)) begin
          if (retry_q < 4'(MAX_RETRY)) begin
            retry_d = retry_q + 4'd1;
            state_d = SEND;
          end else begin
            code_d  = FATAL_ERROR;
            state_d = REPORT;
          end
        end else if (dst_strobe) begin
          code_d  = FATAL_ERROR;
          state_d = REPORT;
        end
      end
      REPORT: begin
        bus.conf_out       = code_q;
        bus.conf_out_valid = NUM_PORTS'(1) << src_q;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      src_q   <= '0;
      frame_q <= '0;
      retry_q <= '0;
      code_q  <= '0;
      fatal_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      frame_q <= frame_d;
      retry_q <= retry_d;
      code_q  <= code_d;
      if (state_q == REPORT && code_q == FATAL_ERROR && fatal_q != '1)
        fatal_q <= fatal_q + 16'd1;
    end
  end

  assign bus.fout  = frame_q;
  assign busy      = (state_q != IDLE);
  assign fatal_cnt = fatal_q;

endmodule

// File: tb/tb_frame_relay_core.sv
// Directed bench for frame_relay_core: 2-port and 4-port instances, plus a
// timeout instance when RELAY_TIMEOUT_EN is defined.
module tb_frame_relay_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  frame_relay_core_if #(.NUM_PORTS(2), .FRAME_BITS(696)) b2 ();
  frame_relay_core_if #(.NUM_PORTS(4), .FRAME_BITS(696)) b4 ();
  logic        busy2, busy4;
  logic [15:0] fc2, fc4;

  frame_relay_core #(.NUM_PORTS(2), .FRAME_BITS(696), .MAX_RETRY(3), .TIMEOUT_CYC(100)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .busy(busy2), .fatal_cnt(fc2));

  frame_relay_core #(.NUM_PORTS(4), .FRAME_BITS(696), .MAX_RETRY(3), .TIMEOUT_CYC(100)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4), .busy(busy4), .fatal_cnt(fc4));

`ifdef RELAY_TIMEOUT_EN
  frame_relay_core_if #(.NUM_PORTS(2), .FRAME_BITS(696)) bt ();
  logic        busyt;
  logic [15:0] fct;
  frame_relay_core #(.NUM_PORTS(2), .FRAME_BITS(696), .MAX_RETRY(1), .TIMEOUT_CYC(100)) dutt (
    .clk(clk), .rst_n(rst_n), .bus(bt), .busy(busyt), .fatal_cnt(fct));
`endif

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    #3;
    tests++; if (b2.fin_ready !== 2'b00) begin fails++; $display("FAIL reset_fin_ready got %b exp 00", b2.fin_ready); end
    tests++; if (b2.fout_valid !== 2'b00) begin fails++; $display("FAIL reset_fout_valid got %b exp 00", b2.fout_valid); end
    tests++; if (b2.conf_out_valid !== 2'b00) begin fails++; $display("FAIL reset_conf_out_valid got %b exp 00", b2.conf_out_valid); end
    tests++; if (b2.conf_out !== 8'h00) begin fails++; $display("FAIL reset_conf_out got %h exp 00", b2.conf_out); end
    tests++; if (b2.fout !== '0) begin fails++; $display("FAIL reset_fout got %h exp 0", b2.fout); end
    tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy2); end
    tests++; if (fc2 !== 16'h0) begin fails++; $display("FAIL reset_fatal_cnt got %h exp 0", fc2); end
    tests++; if (b4.fout_valid !== 4'b0000) begin fails++; $display("FAIL reset_fout_valid4 got %b exp 0000", b4.fout_valid); end
    @(posedge clk); #2; rst_n = 1'b1;
  endtask

  task automatic test_okay(input logic [7:0] pat, input string tag, input logic [15:0] exp_fc);
    logic [695:0] fr;
    fr = {87{pat}};
    @(posedge clk); #1;
    b2.fin[695:0] = fr; b2.fin_valid = 2'b01; b2.fout_ready = 2'b10;
    #1;
    tests++; if (b2.fin_ready !== 2'b01) begin fails++; $display("FAIL %s_fin_ready got %b exp 01", tag, b2.fin_ready); end
    tests++; if (b2.fout_valid !== 2'b00) begin fails++; $display("FAIL %s_excl got %b exp 00", tag, b2.fout_valid); end
    @(posedge clk); #1; b2.fin_valid = '0; #1;
    tests++; if (b2.fout_valid !== 2'b10) begin fails++; $display("FAIL %s_fout_valid got %b exp 10", tag, b2.fout_valid); end
    tests++; if (b2.fout !== fr) begin fails++; $display("FAIL %s_fout got %h exp %h", tag, b2.fout, fr); end
    tests++; if (busy2 !== 1'b1) begin fails++; $display("FAIL %s_busy got %b exp 1", tag, busy2); end
    @(posedge clk); #2;
    tests++; if (b2.fout_valid !== 2'b00) begin fails++; $display("FAIL %s_wait_fout_valid got %b exp 00", tag, b2.fout_valid); end
    @(posedge clk); #1;
    @(posedge clk); #1; b2.conf_in[15:8] = 8'h05; b2.conf_in_valid = 2'b10;
    @(posedge clk); #1; b2.conf_in_valid = '0; #1;
    tests++; if (b2.conf_out !== 8'h05) begin fails++; $display("FAIL %s_conf_out got %h exp 05", tag, b2.conf_out); end
    tests++; if (b2.conf_out_valid !== 2'b01) begin fails++; $display("FAIL %s_conf_out_valid got %b exp 01", tag, b2.conf_out_valid); end
    @(posedge clk); #2;
    tests++; if (b2.conf_out_valid !== 2'b00) begin fails++; $display("FAIL %s_cov_pulse got %b exp 00", tag, b2.conf_out_valid); end
    tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL %s_idle_busy got %b exp 0", tag, busy2); end
    tests++; if (fc2 !== exp_fc) begin fails++; $display("FAIL %s_fatal_cnt got %0d exp %0d", tag, fc2, exp_fc); end
    b2.fout_ready = '0;
  endtask

  task automatic test_retry();
    logic [695:0] fr;
    int sends, since, resp;
    bit done;
    logic [7:0] got_code;
    logic [1:0] got_v;
    fr = {87{8'h5A}};
    sends = 0; since = -1; resp = 0; done = 0; got_code = '0; got_v = '0;
    @(posedge clk); #1;
    b2.fin[1391:696] = fr; b2.fin_valid = 2'b10; b2.fout_ready = 2'b01;
    #1;
    tests++; if (b2.fin_ready !== 2'b10) begin fails++; $display("FAIL retry_fin_ready got %b exp 10", b2.fin_ready); end
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk); #1;
      b2.fin_valid = '0; b2.conf_in_valid = '0;
      if (since == 3 && resp < 4) begin
        b2.conf_in[7:0] = 8'h04; b2.conf_in_valid = 2'b01; resp++;
      end
      #1;
      if (b2.fout_valid == 2'b01) begin
        sends++; since = 0;
        tests++; if (b2.fout !== fr) begin fails++; $display("FAIL retry_fout got %h exp %h", b2.fout, fr); end
      end else if (since >= 0) since++;
      if (b2.conf_out_valid != 2'b00) begin done = 1; got_code = b2.conf_out; got_v = b2.conf_out_valid; end
    end
    tests++; if (!done) begin fails++; $display("FAIL retry_timeout got no report exp report"); end
    tests++; if (sends !== 4) begin fails++; $display("FAIL retry_sends got %0d exp 4", sends); end
    tests++; if (got_code !== 8'h08) begin fails++; $display("FAIL retry_code got %h exp 08", got_code); end
    tests++; if (got_v !== 2'b10) begin fails++; $display("FAIL retry_target got %b exp 10", got_v); end
    @(posedge clk); #2;
    tests++; if (fc2 !== 16'd1) begin fails++; $display("FAIL retry_fatal_cnt got %0d exp 1", fc2); end
    tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL retry_busy got %b exp 0", busy2); end
    b2.fout_ready = '0;
  endtask

  task automatic test_unknown();
    @(posedge clk); #1;
    b2.fin[695:0] = {87{8'hC3}}; b2.fin_valid = 2'b01; b2.fout_ready = 2'b10;
    @(posedge clk); #1;
    b2.fin_valid = '0; b2.conf_in[15:8] = 8'h05; b2.conf_in_valid = 2'b10;
    #1;
    tests++; if (b2.fout_valid !== 2'b10) begin fails++; $display("FAIL unk_send got %b exp 10", b2.fout_valid); end
    @(posedge clk); #1; b2.conf_in_valid = '0; #1;
    tests++; if (b2.conf_out_valid !== 2'b00) begin fails++; $display("FAIL unk_send_strobe got %b exp 00", b2.conf_out_valid); end
    tests++; if (busy2 !== 1'b1) begin fails++; $display("FAIL unk_busy got %b exp 1", busy2); end
    @(posedge clk); #1; b2.conf_in[7:0] = 8'h05; b2.conf_in_valid = 2'b01; #1;
    @(posedge clk); #1; b2.conf_in_valid = '0; #1;
    tests++; if (b2.conf_out_valid !== 2'b00) begin fails++; $display("FAIL unk_stray got %b exp 00", b2.conf_out_valid); end
    tests++; if (b2.fout_valid !== 2'b00) begin fails++; $display("FAIL unk_resend got %b exp 00", b2.fout_valid); end
    @(posedge clk); #1; b2.conf_in[15:8] = 8'h33; b2.conf_in_valid = 2'b10;
    @(posedge clk); #1; b2.conf_in_valid = '0; #1;
    tests++; if (b2.conf_out !== 8'h08) begin fails++; $display("FAIL unk_code got %h exp 08", b2.conf_out); end
    tests++; if (b2.conf_out_valid !== 2'b01) begin fails++; $display("FAIL unk_target got %b exp 01", b2.conf_out_valid); end
    @(posedge clk); #2;
    tests++; if (fc2 !== 16'd2) begin fails++; $display("FAIL unk_fatal_cnt got %0d exp 2", fc2); end
    tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL unk_idle got %b exp 0", busy2); end
    b2.fout_ready = '0;
  endtask

  task automatic test_round_robin();
    int gr[$];
    int ds[$];
    int rp[$];
    int exp_g[5] = '{0, 1, 2, 3, 0};
    int exp_d[5] = '{1, 0, 3, 2, 1};
    int since, pend_dst, nconf;
    logic [7:0] b;
    since = -1; pend_dst = 0; nconf = 0;
    for (int i = 0; i < 4; i++) begin
      b = 8'h10 + 8'(i);
      b4.fin[i*696 +: 696] = {87{b}};
    end
    @(posedge clk); #1;
    b4.fin_valid = 4'b1111; b4.fout_ready = 4'b1111;
    for (int c = 0; c < 200 && nconf < 5; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      b4.conf_in_valid = '0;
      if (gr.size() >= 5) b4.fin_valid = '0;
      if (since == 2) begin b4.conf_in[pend_dst*8 +: 8] = 8'h05; b4.conf_in_valid[pend_dst] = 1'b1; end
      #1;
      if (b4.fin_ready != 4'b0000) begin
        gr.push_back(oh_idx(b4.fin_ready));
        tests++; if (b4.fout_valid !== 4'b0000) begin fails++; $display("FAIL rr_excl got %b exp 0000", b4.fout_valid); end
      end
      if (b4.fout_valid != 4'b0000) begin
        pend_dst = oh_idx(b4.fout_valid); ds.push_back(pend_dst); since = 0;
        b = 8'h10 + 8'(gr[gr.size()-1]);
        tests++; if (b4.fout !== {87{b}}) begin fails++; $display("FAIL rr_fout got %h exp %h", b4.fout, {87{b}}); end
      end else if (since >= 0) since++;
      if (b4.conf_out_valid != 4'b0000) begin
        rp.push_back(oh_idx(b4.conf_out_valid)); nconf++;
        tests++; if (b4.conf_out !== 8'h05) begin fails++; $display("FAIL rr_code got %h exp 05", b4.conf_out); end
      end
    end
    tests++; if (nconf != 5) begin fails++; $display("FAIL rr_timeout got %0d reports exp 5", nconf); end
    for (int k = 0; k < 5; k++) begin
      tests++; if (k >= gr.size() || gr[k] != exp_g[k]) begin fails++; $display("FAIL rr_grant%0d got %0d exp %0d", k, (k < gr.size()) ? gr[k] : -1, exp_g[k]); end
      tests++; if (k >= ds.size() || ds[k] != exp_d[k]) begin fails++; $display("FAIL rr_dst%0d got %0d exp %0d", k, (k < ds.size()) ? ds[k] : -1, exp_d[k]); end
      tests++; if (k >= rp.size() || rp[k] != exp_g[k]) begin fails++; $display("FAIL rr_report%0d got %0d exp %0d", k, (k < rp.size()) ? rp[k] : -1, exp_g[k]); end
    end
    @(posedge clk); #2;
    tests++; if (busy4 !== 1'b0) begin fails++; $display("FAIL rr_idle got %b exp 0", busy4); end
    tests++; if (fc4 !== 16'd0) begin fails++; $display("FAIL rr_fatal_cnt got %0d exp 0", fc4); end
    b4.fout_ready = '0;
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    b2.fin[695:0] = {87{8'h77}}; b2.fin_valid = 2'b01; b2.fout_ready = 2'b10;
    @(posedge clk); #1; b2.fin_valid = '0;
    @(posedge clk); #2;
    tests++; if (busy2 !== 1'b1) begin fails++; $display("FAIL rst_mid_busy_before got %b exp 1", busy2); end
    rst_n = 1'b0; b2.fout_ready = '0; #1;
    tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b exp 0", busy2); end
    tests++; if (b2.fout !== '0) begin fails++; $display("FAIL rst_mid_fout got %h exp 0", b2.fout); end
    tests++; if (b2.fout_valid !== 2'b00) begin fails++; $display("FAIL rst_mid_fout_valid got %b exp 00", b2.fout_valid); end
    tests++; if (b2.conf_out_valid !== 2'b00) begin fails++; $display("FAIL rst_mid_cov got %b exp 00", b2.conf_out_valid); end
    tests++; if (fc2 !== 16'd0) begin fails++; $display("FAIL rst_mid_fatal_cnt got %0d exp 0", fc2); end
    @(posedge clk); #2; rst_n = 1'b1;
    test_okay(8'h3C, "after_rst", 16'd0);
  endtask

`ifdef RELAY_TIMEOUT_EN
  task automatic test_timeout();
    int hs[$];
    int rep;
    logic [7:0] code;
    logic [1:0] cov;
    rep = -1; code = '0; cov = '0;
    @(posedge clk); #1;
    bt.fin[695:0] = {87{8'h99}}; bt.fin_valid = 2'b01; bt.fout_ready = 2'b10;
    for (int c = 0; c < 400 && rep < 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 1) bt.fin_valid = '0;
      #1;
      if (bt.fout_valid == 2'b10) hs.push_back(c);
      if (bt.conf_out_valid != 2'b00) begin rep = c; code = bt.conf_out; cov = bt.conf_out_valid; end
    end
    tests++; if (hs.size() != 2) begin fails++; $display("FAIL tmo_sends got %0d exp 2", hs.size()); end
    tests++; if (rep < 0) begin fails++; $display("FAIL tmo_no_report got none exp report"); end
    if (hs.size() == 2) begin
      tests++; if (hs[1] - hs[0] != 101) begin fails++; $display("FAIL tmo_gap got %0d exp 101", hs[1] - hs[0]); end
      tests++; if (rep - hs[1] != 101) begin fails++; $display("FAIL tmo_report_gap got %0d exp 101", rep - hs[1]); end
    end
    tests++; if (code !== 8'h08) begin fails++; $display("FAIL tmo_code got %h exp 08", code); end
    tests++; if (cov !== 2'b01) begin fails++; $display("FAIL tmo_target got %b exp 01", cov); end
    bt.fout_ready = '0;
  endtask
`endif

  initial begin
    b2.fin = '0; b2.fin_valid = '0; b2.fout_ready = '0; b2.conf_in = '0; b2.conf_in_valid = '0;
    b4.fin = '0; b4.fin_valid = '0; b4.fout_ready = '0; b4.conf_in = '0; b4.conf_in_valid = '0;
`ifdef RELAY_TIMEOUT_EN
    bt.fin = '0; bt.fin_valid = '0; bt.fout_ready = '0; bt.conf_in = '0; bt.conf_in_valid = '0;
`endif
    test_reset();
    test_okay(8'hA5, "okay", 16'd0);
    test_retry();
    test_unknown();
    test_round_robin();
    test_reset_midflight();
`ifdef RELAY_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
